layer1_param_sched: RTL

- Fetch scheduler for the first conv/BN layer's parameter loader.
- Shares one external parameter read port between two requesters:
  - conv reuse pass request (pc_reuse pulse), which needs a full weight group;
  - BN reuse request (mo_reuse pulse), which needs one channel's coefficient pair.
- Generates burst addresses and forwards returned words to the loader as the tagged i_param_vld[2:0] / i_param stream.
- Sits between the parameter memory and the loader, inside the layer wrapper.

---
 rtl/layer1_param_sched_pkg.sv | 28 ++
 rtl/layer1_param_sched_rr_arb2.sv | 26 ++
 rtl/layer1_param_sched.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/layer1_param_sched_pkg.sv
// Shared types and constants for the layer-1 parameter fetch scheduler:
// word tags, FSM state encoding and burst-size derivations.
package layer1_sched_pkg;

  localparam logic [2:0] TAG_CW  = 3'b001;
  localparam logic [2:0] TAG_BNA = 3'b010;
  localparam logic [2:0] TAG_BNB = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } sched_state_e;

  // One word carries three weights of one thread, so a group is len_w^2 words per thread.
  function automatic int cw_words(input int len_w, input int thread);
    return len_w * len_w * thread;
  endfunction

  function automatic int groups(input int channel, input int thread);
    return channel / thread;
  endfunction

  function automatic int bn_words();
    return 2;
  endfunction

endpackage

// File: rtl/layer1_param_sched_rr_arb2.sv
// Two-requester round-robin arbiter; the requester not granted last wins a tie.
// After reset requester 0 has priority.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_1;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_1)) gnt = 2'b01;
    else if (req[1])                   gnt = 2'b10;
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n)               last_1 <= 1'b1;
    else if (en && (|req))    last_1 <= gnt[1];
  end

endmodule

// File: rtl/layer1_param_sched.sv
// Parameter fetch scheduler sharing one read port between conv weight groups and BN
// coefficient pairs. Define PARAM_PREFETCH_EN to auto-fetch conv group 0 each frame.
module layer1_param_sched
  import layer1_sched_pkg::*;
#(
  parameter int WIDTH_P  = 60,
  parameter int WIDTH_AD = 24,
  parameter int THREAD   = 2,
  parameter int CHANNEL  = 64,
  parameter int LEN_W    = 7,
  parameter int CW_BASE  = 0,
  parameter int BN_BASE  = 4096
) (
  input  logic                i_sclk,
  input  logic                i_rstn,
  input  logic                i_vsync,
  input  logic                i_conv_req,
  input  logic                i_bn_req,
  output logic                o_rd_req,
  input  logic                i_rd_ack,
  output logic [WIDTH_AD-1:0] o_rd_addr,
  output logic [7:0]          o_rd_len,
  input  logic                i_rd_valid,
  input  logic [WIDTH_P-1:0]  i_rd_data,
  output logic [2:0]          o_param_vld,
  output logic [WIDTH_P-1:0]  o_param,
  output logic                o_busy,
  output logic                o_err
);

  localparam int CW_WORDS = cw_words(LEN_W, THREAD);
  localparam int GROUPS   = groups(CHANNEL, THREAD);
  localparam int BN_WORDS = bn_words();
  localparam int IDX_W    = 16;

  sched_state_e     state;
  logic             cw_pend, bn_pend;
  logic             gnt_bn;    // granted requester of the burst in REQ/DATA
  logic             no_inc;    // vsync hit this burst: finish it but keep the rewound index
  logic             armed;     // stray beats only count as errors after a grant
  logic [IDX_W-1:0] cw_idx, bn_idx;
  logic [7:0]       beat_cnt;

  logic             beat, last_beat, cw_done, bn_done, ack_now;
  logic             consume, cw_err, bn_err, stray, cw_set, bn_set, arb_en;
  logic [1:0]       arb_gnt;
  logic [WIDTH_AD-1:0] cw_addr, bn_addr;

`ifdef PARAM_PREFETCH_EN
  logic pf_due, skip_first;
  assign consume = i_conv_req && (skip_first || i_vsync);
`else
  assign consume = 1'b0;
`endif

  always_comb begin
    beat      = (state == DATA) && i_rd_valid;
    last_beat = beat && (beat_cnt == 8'd0);
    cw_done   = last_beat && !gnt_bn;
    bn_done   = last_beat && gnt_bn;
    ack_now   = (state == REQ) && i_rd_ack;
    // A pulse is dropped if its flag is still pending or its own burst is still running.
    cw_err    = i_conv_req && !consume &&
                ((cw_pend && !i_vsync) || ((state != IDLE) && !gnt_bn && !cw_done));
    bn_err    = i_bn_req &&
                ((bn_pend && !i_vsync) || ((state != IDLE) && gnt_bn && !bn_done));
    cw_set    = i_conv_req && !consume && !cw_err;
    bn_set    = i_bn_req && !bn_err;
    stray     = i_rd_valid && (state != DATA) && armed;
    arb_en    = (state == IDLE) && !i_vsync && (cw_pend || cw_set || bn_pend || bn_set);
    cw_addr   = WIDTH_AD'(CW_BASE) + WIDTH_AD'(cw_idx) * WIDTH_AD'(CW_WORDS);
    bn_addr   = WIDTH_AD'(BN_BASE) + WIDTH_AD'(bn_idx) * WIDTH_AD'(BN_WORDS);
  end

  rr_arb2 u_arb (
    .clk   (i_sclk),
    .rst_n (i_rstn),
    .req   ({bn_pend || bn_set, cw_pend || cw_set}),
    .en    (arb_en),
    .gnt   (arb_gnt)
  );

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      state       <= IDLE;
      cw_pend     <= 1'b0;
      bn_pend     <= 1'b0;
      gnt_bn      <= 1'b0;
      no_inc      <= 1'b0;
      armed       <= 1'b0;
      cw_idx      <= '0;
      bn_idx      <= '0;
      beat_cnt    <= '0;
      o_rd_req    <= 1'b0;
      o_rd_addr   <= '0;
      o_rd_len    <= '0;
      o_param_vld <= '0;
      o_param     <= '0;
      o_err       <= 1'b0;
`ifdef PARAM_PREFETCH_EN
      pf_due      <= 1'b1;
      skip_first  <= 1'b1;
`endif
    end else begin
      o_param_vld <= '0;
      if (cw_err || bn_err || stray) o_err <= 1'b1;

      if (i_vsync) begin
        cw_pend <= cw_set;
        bn_pend <= bn_set;
      end else begin
        cw_pend <= (cw_pend && !(ack_now && !gnt_bn)) || cw_set;
        bn_pend <= (bn_pend && !(ack_now &&  gnt_bn)) || bn_set;
      end

`ifdef PARAM_PREFETCH_EN
      pf_due <= 1'b0;
      if (pf_due || i_vsync) cw_pend <= 1'b1;
      if (i_vsync)           skip_first <= !i_conv_req;
      else if (i_conv_req)   skip_first <= 1'b0;
`endif

      if (i_vsync) begin
        cw_idx <= '0;
        bn_idx <= '0;
      end else if (last_beat && !no_inc) begin
        if (gnt_bn) bn_idx <= (bn_idx == IDX_W'(CHANNEL - 1)) ? '0 : bn_idx + 1'b1;
        else        cw_idx <= (cw_idx == IDX_W'(GROUPS - 1))  ? '0 : cw_idx + 1'b1;
      end

      if (arb_en)                          no_inc <= 1'b0;
      else if (i_vsync && state != IDLE)   no_inc <= 1'b1;

      case (state)
        IDLE: begin
          if (arb_en) begin
            gnt_bn    <= arb_gnt[1];
            armed     <= 1'b1;
            o_rd_req  <= 1'b1;
            o_rd_addr <= arb_gnt[0] ? cw_addr : bn_addr;
            o_rd_len  <= arb_gnt[0] ? 8'(CW_WORDS - 1) : 8'(BN_WORDS - 1);
            state     <= REQ;
          end
        end
        REQ: begin
          if (i_rd_ack) begin
            o_rd_req <= 1'b0;
            beat_cnt <= o_rd_len;
            state    <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            o_param     <= i_rd_data;
            // BN pair counts down 1 -> 0, so the first beat is the a coefficient.
            o_param_vld <= !gnt_bn ? TAG_CW : ((beat_cnt == 8'd0) ? TAG_BNB : TAG_BNA);
            beat_cnt    <= beat_cnt - 8'd1;
            if (beat_cnt == 8'd0) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
